autolock_hyst: RTL
==================

// Module: autolock_hyst
// PURPOSE
//  Parametrised successor of the lock-acquisition controller. Gates scanning and the PI
//  regulator enable from a discriminator signal, per channel.
//  Adds separate lock/unlock thresholds (hysteresis) and N-sample acquisition qualification.
//  Adds a loss hold-off timeout, a bounded relock retry count and a FAIL state, plus status
//  outputs. Sits between the demodulator update strobe and the picore/scan generator gates.
// PARAMETERS
//  WIDTH       16  discriminator/threshold width, two's-complement signed
//  CNT_WIDTH   16  width of acquire_count, timeout and internal sample counters
//  RETRY_WIDTH  8  width of max_retries and lock_lost_count
// PORTS
//  clk               in   1            system clock
//  sclr              in   1            synchronous active-high reset
//  update            in   1            one-cycle strobe: discriminator valid
//  enable            in   1            level; 0 forces IDLE
//  discriminator     in   WIDTH        signed lock-quality signal
//  lock_threshold    in   WIDTH        signed; disc >= this counts toward lock
//  unlock_threshold  in   WIDTH        signed; disc < this while locked = loss candidate
//  acquire_count     in   CNT_WIDTH    consecutive good updates needed (0 treated as 1)
//  timeout           in   CNT_WIDTH    consecutive bad updates tolerated in HOLD
//  max_retries       in   RETRY_WIDTH  lock losses allowed before FAIL; 0 = unlimited
//  clear_stats       in   1            one-cycle pulse: clear lock_lost_count
//  enable_lock_out   out  1            PI regulator gate
//  scan_enable       out  1            scan generator gate
//  status            out  3            state code: IDLE=0 SCAN=1 LOCKED=2 HOLD=3 FAIL=4
//  failed            out  1            high in FAIL
//  lock_lost_count   out  RETRY_WIDTH  saturating count of lock losses since clear
// BEHAVIOUR
//  - Outputs are registered; a state change is visible one clk after the deciding cycle.
//  - Reset: state=IDLE. enable_lock_out=0, scan_enable=0, failed=0, status=0.
//    lock_lost_count=0 and all internal counters 0.
//  - Comparisons are signed, full WIDTH. Thresholds are sampled on the update cycle.
//  - Priority: sclr > enable==0 > update-driven transitions > clear_stats (independent).
//  - IDLE: both gates 0. enable==1 -> SCAN; clear acq_cnt, hold_cnt, retry_cnt.
//  - SCAN: scan_enable=1, enable_lock_out=0.
//    On update: disc>=lock_threshold -> acq_cnt+1, else acq_cnt=0.
//    When the incremented acq_cnt == max(acquire_count,1) -> LOCKED; acq_cnt cleared.
//  - LOCKED: enable_lock_out=1, scan_enable=0.
//    On update with disc<unlock_threshold -> HOLD with hold_cnt=1.
//    With timeout==0 a bad update is an immediate loss; skip HOLD.
//  - HOLD: enable_lock_out=1 (regulator kept running), scan_enable=0.
//    On update: disc>=unlock_threshold -> LOCKED, hold_cnt=0.
//    Otherwise hold_cnt+1. When hold_cnt reaches timeout, that update is a loss event.
//    No update -> no count; time is measured in updates, not clks.
//  - Loss event: lock_lost_count+1 (saturates at all-ones), retry_cnt+1.
//    If max_retries!=0 and the new retry_cnt >= max_retries -> FAIL, else -> SCAN.
//    Both exits leave enable_lock_out=0 on the next cycle.
//  - FAIL: both gates 0, failed=1. Held until enable==0 (-> IDLE); update is ignored.
//  - enable==0 in any state: next cycle IDLE with gates 0, even if update is also present.
//    retry_cnt, acq_cnt and hold_cnt clear; lock_lost_count is retained.
//  - clear_stats zeroes lock_lost_count next cycle. If it coincides with a loss event,
//    the result is 0 (clear wins).
//  - unlock_threshold > lock_threshold is legal. Re-qualification then only happens via SCAN.
//  - Counters never wrap. acq_cnt/hold_cnt stop at their targets;
//    acquire_count/timeout changes take effect at the next update compare.
// TESTING
//  1 Reset then enable=1, disc=-20, lock_th=1000: status=1 and scan_enable=1 after 1 clk.
//    Stays SCAN across 10 updates.
//  2 acquire_count=3, disc=12000 on 3 updates: LOCKED one clk after the 3rd update.
//    A bad update at the 2nd sample restarts the count: needs 3 more.
//  3 LOCKED, unlock_th=500, timeout=4: disc=100 on 3 updates then 600 -> back to LOCKED,
//    count=0. Disc=100 on 4 updates -> SCAN, lock_lost_count=1.
//  4 max_retries=2: two loss events -> FAIL, failed=1, both gates 0.
//    enable=0 -> IDLE. enable=1 -> SCAN with retries reset, lost count still 2.
//  5 enable falls on the same clk as a qualifying update in SCAN -> IDLE, never LOCKED.
//    sclr mid-HOLD -> all outputs at reset values next clk.
//  6 timeout=0: single bad update in LOCKED -> SCAN directly.
//    clear_stats coincident with the loss -> lock_lost_count=0.

Source files
------------

// File: rtl/autolock_hyst.sv
// -----------------------------------------------------------------------------
// autolock_hyst
//   Per-channel lock-acquisition controller. Watches a signed discriminator that
//   is valid on the `update` strobe and gates the scan generator and the PI
//   regulator accordingly. Lock is qualified by N consecutive good samples. Loss
//   uses a separate (hysteretic) unlock threshold and a hold-off measured in
//   updates. Repeated losses are counted, and a bounded retry budget ends in FAIL.
//
// Ports
//   clk, sclr          clock, synchronous active-high reset
//   update             one-cycle strobe, discriminator valid
//   enable             level; low forces IDLE
//   discriminator      signed lock-quality sample
//   lock_threshold     disc >= this counts toward lock (signed)
//   unlock_threshold   disc <  this while locked is a loss candidate (signed)
//   acquire_count      consecutive good updates needed (0 behaves as 1)
//   timeout            consecutive bad updates tolerated in HOLD
//   max_retries        losses allowed before FAIL, 0 = unlimited
//   clear_stats        pulse, clears lock_lost_count
//   enable_lock_out    PI regulator gate (LOCKED or HOLD)
//   scan_enable        scan generator gate (SCAN)
//   status             IDLE=0 SCAN=1 LOCKED=2 HOLD=3 FAIL=4
//   failed             high in FAIL
//   lock_lost_count    saturating count of loss events since clear
// All outputs are registered and reflect the state decided on the previous clk.
// -----------------------------------------------------------------------------
module autolock_hyst #(
  parameter int WIDTH       = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int RETRY_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          sclr,
  input  logic                          update,
  input  logic                          enable,
  input  logic signed [WIDTH-1:0]       discriminator,
  input  logic signed [WIDTH-1:0]       lock_threshold,
  input  logic signed [WIDTH-1:0]       unlock_threshold,
  input  logic        [CNT_WIDTH-1:0]   acquire_count,
  input  logic        [CNT_WIDTH-1:0]   timeout,
  input  logic        [RETRY_WIDTH-1:0] max_retries,
  input  logic                          clear_stats,
  output logic                          enable_lock_out,
  output logic                          scan_enable,
  output logic        [2:0]             status,
  output logic                          failed,
  output logic        [RETRY_WIDTH-1:0] lock_lost_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_LOCKED = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   acq_cnt_q, acq_cnt_d;
  logic [CNT_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
  logic [RETRY_WIDTH-1:0] retry_cnt_q, retry_cnt_d;
  logic [RETRY_WIDTH-1:0] lost_cnt_q, lost_cnt_d;

  logic                   lock_out_q, lock_out_d;
  logic                   scan_q, scan_d;
  logic [2:0]             status_q, status_d;
  logic                   failed_q, failed_d;

  logic                   disc_good;
  logic                   disc_bad;
  logic                   loss;
  logic [CNT_WIDTH-1:0]   acq_target;
  logic [CNT_WIDTH-1:0]   acq_inc;
  logic [CNT_WIDTH-1:0]   hold_inc;
  logic [RETRY_WIDTH-1:0] retry_inc;
  logic [RETRY_WIDTH-1:0] lost_inc;

  always_comb begin
    disc_good  = (discriminator >= lock_threshold);
    disc_bad   = (discriminator <  unlock_threshold);
    acq_target = (acquire_count == '0) ? CNT_WIDTH'(1) : acquire_count;
    // Counters stay below their targets, so these increments cannot overflow.
    acq_inc    = acq_cnt_q + CNT_WIDTH'(1);
    hold_inc   = hold_cnt_q + CNT_WIDTH'(1);
    retry_inc  = (&retry_cnt_q) ? retry_cnt_q : retry_cnt_q + RETRY_WIDTH'(1);
    lost_inc   = (&lost_cnt_q)  ? lost_cnt_q  : lost_cnt_q  + RETRY_WIDTH'(1);

    state_d     = state_q;
    acq_cnt_d   = acq_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    retry_cnt_d = retry_cnt_q;
    lost_cnt_d  = lost_cnt_q;
    loss        = 1'b0;

    if (!enable) begin
      state_d     = ST_IDLE;
      acq_cnt_d   = '0;
      hold_cnt_d  = '0;
      retry_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_SCAN;
          acq_cnt_d   = '0;
          hold_cnt_d  = '0;
          retry_cnt_d = '0;
        end
        ST_SCAN: begin
          if (update) begin
            if (disc_good) begin
              // >= rather than == so a lowered acquire_count cannot be overrun.
              if (acq_inc >= acq_target) begin
                state_d   = ST_LOCKED;
                acq_cnt_d = '0;
              end else begin
                acq_cnt_d = acq_inc;
              end
            end else begin
              acq_cnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (update && disc_bad) begin
            // First bad sample makes hold_cnt 1; if that already meets the
            // timeout (0 or 1) the loss is immediate and HOLD is skipped.
            if (timeout <= CNT_WIDTH'(1)) begin
              loss = 1'b1;
            end else begin
              state_d    = ST_HOLD;
              hold_cnt_d = CNT_WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (update) begin
            if (!disc_bad) begin
              state_d    = ST_LOCKED;
              hold_cnt_d = '0;
            end else if (hold_inc >= timeout) begin
              loss = 1'b1;
            end else begin
              hold_cnt_d = hold_inc;
            end
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (loss) begin
        lost_cnt_d  = lost_inc;
        retry_cnt_d = retry_inc;
        hold_cnt_d  = '0;
        acq_cnt_d   = '0;
        if ((max_retries != '0) && (retry_inc >= max_retries)) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_SCAN;
        end
      end
    end

    // Statistics clear is independent of the state machine and wins over a loss.
    if (clear_stats) begin
      lost_cnt_d = '0;
    end

    lock_out_d = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
    scan_d     = (state_d == ST_SCAN);
    failed_d   = (state_d == ST_FAIL);
    status_d   = state_d;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q     <= ST_IDLE;
      acq_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      retry_cnt_q <= '0;
      lost_cnt_q  <= '0;
      lock_out_q  <= 1'b0;
      scan_q      <= 1'b0;
      status_q    <= 3'd0;
      failed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acq_cnt_q   <= acq_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
      lock_out_q  <= lock_out_d;
      scan_q      <= scan_d;
      status_q    <= status_d;
      failed_q    <= failed_d;
    end
  end

  assign enable_lock_out = lock_out_q;
  assign scan_enable     = scan_q;
  assign status          = status_q;
  assign failed          = failed_q;
  assign lock_lost_count = lost_cnt_q;

endmodule
